// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - parameterizable positive-edge D register with synchronous active-low reset
module d_flip_flop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // No initial value: q stays unknown until the first rising edge loads it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - scoreboard bench for d_flip_flop, default and 8-bit/A5 instances
module tb_d_flip_flop;

    logic       clk = 1'b0;
    logic       reset;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;

    typedef struct packed {
        logic       e1;
        logic [7:0] e8;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   glitch_en = 1'b0;

    d_flip_flop u_dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1)
    );

    d_flip_flop #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8)
    );

    always #10 clk = ~clk;

    // Reference: value the register must hold after the edge that samples these inputs.
    function automatic exp_t model(input logic r, input logic v1, input logic [7:0] v8);
        exp_t e;
        if (r == 1'b0) begin
            e.e1 = 1'b0;
            e.e8 = 8'hA5;
        end else begin
            e.e1 = v1;
            e.e8 = v8;
        end
        return e;
    endfunction

    task automatic drive(input logic r, input logic v1, input logic [7:0] v8);
        reset = r;
        d1    = v1;
        d8    = v8;
        sb.push_back(model(r, v1, v8));
    endtask

    task automatic step(input logic r, input logic v1, input logic [7:0] v8);
        @(negedge clk);
        drive(r, v1, v8);
    endtask

    task automatic check(input string name, input exp_t e);
        n_checks++;
        if (q1 !== e.e1 || q8 !== e.e8) begin
            n_fail++;
            $display("FAIL %s @%0t: got q1=%b q8=%h, expected q1=%b q8=%h",
                     name, $time, q1, q8, e.e1, e.e8);
        end
    endtask

    // Monitor: every rising edge presents a new q; check it just after the edge,
    // late in the high phase (after mid-cycle glitches), and after the falling edge.
    initial begin
        exp_t cur;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check("capture", cur);
                #8;
                check("hold_high", cur);
                @(negedge clk);
                #5;
                check("hold_low", cur);
            end
        end
    end

    // Mid-cycle disturbance of d and reset while clk is high; none of it may reach q.
    initial begin
        forever begin
            @(posedge clk);
            if (glitch_en) begin
                #3;
                d1    = 1'($urandom);
                d8    = 8'($urandom);
                reset = 1'b0;
                #3;
                d1    = 1'($urandom);
                d8    = 8'($urandom);
                reset = 1'($urandom);
            end
        end
    end

    initial begin
        glitch_en = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        step(1'b1, 1'b1, 8'h3C);
        step(1'b1, 1'b0, 8'hC3);
        step(1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h01);
        step(1'b0, 1'b0, 8'h5A);
        step(1'b1, 1'b1, 8'h3C);
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom), 8'($urandom));
        end
        @(negedge clk);
        glitch_en = 1'b0;
        repeat (2) @(negedge clk);
        #6;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
